// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - hazard inputs and stage-control outputs of the pipeline sequencer
interface pipeline_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             load_use;
  logic             branch_taken;
  logic             md_issue;
  logic             mem_access;
  logic             dmem_ready;
  logic             pc_we;
  logic             if_id_we;
  logic             id_ex_we;
  logic             ex_mem_we;
  logic             mem_wb_we;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             mem_wb_flush;
  logic             busy;
  logic [CNT_W-1:0] stall_cycles;

  // Hazard sources (hazard unit, EX and MEM stages) drive the inputs
  modport master (
    output load_use, branch_taken, md_issue, mem_access, dmem_ready,
    input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
    input  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
    input  busy, stall_cycles
  );

  // The sequencer consumes hazards and drives register controls
  modport slave (
    input  load_use, branch_taken, md_issue, mem_access, dmem_ready,
    output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
    output if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
    output busy, stall_cycles
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer for the five-stage pipeline
module pipeline_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  pipeline_ctrl_if.slave      bus
);

  localparam int MDC_W     = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
  localparam int MD_INIT_I = (MD_LATENCY > 1) ? MD_LATENCY - 2 : 0;
  localparam logic [MDC_W-1:0] MD_INIT = MDC_W'(MD_INIT_I);
  localparam bit MD_MULTI  = (MD_LATENCY > 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MD_WAIT  = 2'd2
  } state_t;

  state_t           state, next_state;
  logic [MDC_W-1:0] md_cnt, next_cnt;
  logic [CNT_W-1:0] stall_q;

  logic pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;

  logic run_eval, allow_p1, allow_p2;
  logic sel_freeze, sel_md;

  // Decide which action governs this cycle, then derive controls and next state
  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    id_ex_we     = 1'b1;
    ex_mem_we    = 1'b1;
    mem_wb_we    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    next_state   = state;
    next_cnt     = md_cnt;
    run_eval     = 1'b0;
    allow_p1     = 1'b1;
    allow_p2     = 1'b1;
    sel_freeze   = 1'b0;
    sel_md       = 1'b0;

    unique case (state)
      RUN: run_eval = 1'b1;
      MEM_WAIT: begin
        if (!bus.dmem_ready) begin
          sel_freeze = 1'b1;
          next_state = MEM_WAIT;
        end else begin
          run_eval = 1'b1;
          allow_p1 = 1'b0;
        end
      end
      MD_WAIT: begin
        // A stray memory stall still wins; otherwise keep counting down
        if (md_cnt != '0 && !(bus.mem_access && !bus.dmem_ready)) begin
          sel_md     = 1'b1;
          next_cnt   = md_cnt - 1'b1;
          next_state = MD_WAIT;
        end else begin
          // md_issue is still high because EX was held; do not re-issue
          run_eval = 1'b1;
          allow_p2 = 1'b0;
        end
      end
      default: run_eval = 1'b1;
    endcase

    if (run_eval) begin
      next_state = RUN;
      if (allow_p1 && bus.mem_access && !bus.dmem_ready) begin
        sel_freeze = 1'b1;
        next_state = MEM_WAIT;
        next_cnt   = '0;
      end else if (allow_p2 && MD_MULTI && bus.md_issue) begin
        sel_md     = 1'b1;
        next_cnt   = MD_INIT;
        next_state = MD_WAIT;
      end else if (bus.branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (bus.load_use) begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end

    if (sel_freeze) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (sel_md) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_flush = 1'b1;
    end

    // Reset holds every stage and fills it with bubbles
    if (reset) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      mem_wb_we    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
    end
  end

  // Sequencer state, mult/div countdown and saturating stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      md_cnt  <= '0;
      stall_q <= '0;
    end else begin
      state  <= next_state;
      md_cnt <= next_cnt;
      if (!pc_we && stall_q != '1) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign bus.pc_we        = pc_we;
  assign bus.if_id_we     = if_id_we;
  assign bus.id_ex_we     = id_ex_we;
  assign bus.ex_mem_we    = ex_mem_we;
  assign bus.mem_wb_we    = mem_wb_we;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.ex_mem_flush = ex_mem_flush;
  assign bus.mem_wb_flush = mem_wb_flush;
  assign bus.busy         = (state != RUN) && !reset;
  assign bus.stall_cycles = stall_q;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the five-stage pipeline. It merges the ID-stage load-use hazard flag, the EX-stage branch-taken signal, a multi-cycle multiply/divide occupancy in EX and a data-memory ready handshake in MEM. From these it produces per-stage register write enables and bubble-insert (flush) controls. It sits beside the hazard unit and drives the PC and IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also exports a busy flag and a saturating stall-cycle counter for performance monitoring.

## Interface
- MD_LATENCY, 4: EX-stage occupancy in cycles of a mult/div instruction (≥1; 1 means single-cycle, md_issue has no effect).
- CNT_W, 16: width of stall_cycles.
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- load_use  input  1  ID-stage load-use hazard detected (combinational from hazard unit).
- branch_taken  input  1  EX-stage branch/jump resolved taken.
- md_issue  input  1  EX-stage instruction is mult/div.
- mem_access  input  1  MEM-stage instruction is lw/sw.
- dmem_ready  input  1  data memory completes the current access this cycle.
- pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we  output  1 each  register load enables (1 = load).
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  output  1 each  load a bubble (NOP, all control zero); flush overrides we.
- busy  output  1  state ≠ RUN.
- stall_cycles  output  CNT_W  count of cycles with pc_we=0, saturating at 2^CNT_W−1.

## Operation
- States: RUN, MEM_WAIT, MD_WAIT. Down-counter md_cnt, width max(1,clog2(MD_LATENCY)).
- Outputs are combinational from state, md_cnt and inputs. Defaults: all we=1, all flush=0.
- RUN evaluation uses a fixed priority.
  - P1: mem_access && !dmem_ready → FREEZE. pc/if_id/id_ex/ex_mem we=0, mem_wb_flush=1. Next state MEM_WAIT.
  - P2: md_issue && MD_LATENCY>1 → MDHOLD. pc/if_id/id_ex we=0, ex_mem_flush=1, mem_wb_we=1. md_cnt←MD_LATENCY−2. Next state MD_WAIT.
  - P3: branch_taken → if_id_flush=1, id_ex_flush=1, all we=1. Overrides load_use.
  - P4: load_use → pc_we=0, if_id_we=0, id_ex_flush=1, others we=1.
  - Otherwise: defaults.
- MEM_WAIT
  - dmem_ready=0: FREEZE, stay.
  - dmem_ready=1: RUN evaluation with P1 masked, and the next-state action of whichever term wins. Normally next state is RUN; if P2 fires, enter MD_WAIT.
- MD_WAIT
  - md_cnt≠0: MDHOLD outputs, md_cnt−1.
  - md_cnt=0 (release): RUN evaluation with P2 masked, since md_issue is still high because EX was held. Next state RUN.
  - mem_access is 0 here (MEM holds a bubble). If it is nevertheless asserted with !dmem_ready, P1 applies and takes priority.
- md_issue and branch_taken asserted together: P2 wins; branch_taken is acted on at release.
- load_use during MDHOLD/FREEZE is ignored; it is re-evaluated when the pipeline advances.
- stall_cycles increments each non-reset cycle in which pc_we=0, then saturates.

## Timing
- Reset high: state←RUN, md_cnt←0, stall_cycles←0. While reset=1, all we=0, all flush=1 and busy=0. First normal cycle is the one after reset deasserts.
- Zero-latency control: outputs respond in the same cycle as their inputs. No registered outputs except stall_cycles and busy, which are state-derived.
- Load-use costs 1 cycle. Taken branch costs 2 squashed slots and 0 stall cycles.
- Memory wait of N cycles with dmem_ready low produces N FREEZE cycles. The pipeline advances in the cycle dmem_ready=1.
- Mult/div: EX is held for MD_LATENCY cycles including the issue cycle, i.e. MD_LATENCY−1 stall cycles. It advances on the release cycle.
- Reset asserted in MEM_WAIT or MD_WAIT aborts the wait: state is RUN on the next cycle, md_cnt=0.

## Test plan
- Reset then idle: reset high 2 cycles → all we=0, flushes=1, stall_cycles=0. Release with all inputs 0 → all we=1, flushes=0, busy=0.
- load_use=1 for 1 cycle → that cycle pc_we=0, if_id_we=0, id_ex_flush=1, ex_mem_we=mem_wb_we=1. stall_cycles=1.
- branch_taken=1 and load_use=1 together → pc_we=1, if_id_flush=id_ex_flush=1. stall_cycles unchanged.
- mem_access=1, dmem_ready low cycles 0–2 and high cycle 3 → FREEZE cycles 0–2, all we=1 at cycle 3. busy high cycles 1–3. stall_cycles +3.
- MD_LATENCY=4, md_issue held with load_use=1 → cycles 0–2: pc_we=0, ex_mem_flush=1, mem_wb_we=1. Cycle 3 release: ex_mem_we=1 and the load-use stall applies (pc_we=0, id_ex_flush=1). stall_cycles +4.
- Reset asserted at the 2nd MEM_WAIT cycle → next cycle busy=0, stall_cycles=0. With dmem_ready=1 and no hazards, all we=1.
